cipher_result_pager: RTL and testbench
======================================

// Module: cipher_result_pager
// PURPOSE
//  Downstream of the AES cipher/invCipher stage. Captures a 128-bit result block and pages through
//  its 16 bytes one at a time on a push-button. Each selected byte is converted to 3 BCD digits by
//  a sequential double-dabble engine (1 bit/cycle). The digits drive the board 7-segment decoders.
// PARAMETERS
//  BLOCK_W    128     width of captured block; must be 128 (16 bytes)
//  DB_CYCLES  500000  cycles a synchronized button level must stay stable to count; benches use 4
// PORTS
//  clk        in   1    single system clock
//  rst        in   1    synchronous, active-high reset
//  load       in   1    1-cycle pulse: capture block_in, select byte 0, start conversion
//  block_in   in   128  cipher output; byte 0 = block_in[127:120] (AES big-endian byte order)
//  step_n     in   1    raw active-low push-button (KEY style), asynchronous to clk
//  byte_idx   out  4    index of the displayed byte, 0..15
//  byte_val   out  8    value of the displayed byte
//  bcd_hund   out  4    hundreds digit, 0..2
//  bcd_tens   out  4    tens digit, 0..9
//  bcd_ones   out  4    ones digit, 0..9
//  bcd_valid  out  1    high when the digits correspond to byte_val
// BEHAVIOUR
//  Reset: block reg=0, byte_idx=0, byte_val=0, all digits=0, bcd_valid=0.
//   FSM=IDLE; debouncer in the released state with its counter cleared.
//   Reset mid-conversion aborts the conversion and forces these values.
//  Button: 2-flop synchronizer, then debounce.
//   A press event is one cycle, issued once the synchronized level has been low for DB_CYCLES
//   consecutive cycles. No further event until it has been high for DB_CYCLES consecutive cycles.
//   A shorter low pulse is ignored and restarts the count.
//  Triggers, sampled at a clock edge:
//   load:  block reg<=block_in; byte_idx<=0.
//   press: byte_idx<=byte_idx+1, wrapping 15->0.
//   load and press in the same cycle: load wins, press event discarded.
//   On either trigger, byte_val takes the newly selected byte at that same edge.
//   Same edge: bcd_valid<=0, FSM->CONV, shift reg<=byte, digits-in-progress<=0, bit count<=0.
//   Digit outputs keep their previous values until conversion completes.
//  FSM:
//   IDLE: wait for trigger.
//   CONV: 8 cycles. Each cycle, every in-progress digit >=5 gets +3, then {hund,tens,ones,shift}
//    shifts left 1. On the 8th CONV edge (count==7): digit outputs and bcd_valid<=1, FSM->IDLE.
//   Latency: bcd_valid rises on the 8th edge after the trigger edge.
//  Trigger during CONV: conversion restarts from scratch with the new byte. bcd_valid stays 0 and
//   the new 8-cycle latency counts from the new trigger edge.
//  Widths: internal digits are 4 bits each; hundreds never exceeds 2 (max 255).
//   No overflow path exists.
//  Outputs are registered; no combinational input-to-output path.
// TESTING
//  T1: rst; load with 0x00112233445566778899aabbccddeeff -> idx=0, val=0x00.
//   valid=0 for 7 edges; at edge 8, digits 0,0,0, valid=1.
//  T2 (DB_CYCLES=4): hold step_n low 6 cycles -> exactly one advance; idx=1, val=0x11.
//   Digits 0,1,7. A 3-cycle low glitch -> no advance.
//  T3: 14 more clean presses -> idx=15, val=0xff, digits 2,5,5. One more press -> idx=0, val=0x00.
//  T4: select idx 9 (0x99) -> 1,5,3. Assert load on the same edge as a press event:
//   idx=0, captured block updated, press lost.
//  T5: press 3 cycles into a conversion -> valid stays 0; digits update 8 edges after 2nd trigger.
//   Assert rst mid-conversion -> all outputs at reset values next edge.
//  T6: random blocks and random press/load timing against a reference model.
//   Every valid=1 cycle: digits == decimal(byte_val).

Source files
------------

// File: rtl/cipher_result_pager.sv
// cipher_result_pager: holds one 128-bit cipher result and pages through its 16 bytes
// on a debounced push-button. The shown byte is converted to three BCD digits by a
// bit-serial double-dabble engine, one bit per cycle.
module cipher_result_pager #(
    parameter int BLOCK_W   = 128,
    parameter int DB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] block_in,
    input  logic               step_n,
    output logic [3:0]         byte_idx,
    output logic [7:0]         byte_val,
    output logic [3:0]         bcd_hund,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones,
    output logic               bcd_valid
);

    localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state;
    state_t             state_nxt;

    logic               step_sync_p0;
    logic               step_sync_p1;
    logic               db_pressed;
    logic               db_active;
    logic [CNT_W-1:0]   db_cnt;
    logic               press_evt;

    logic               trigger;
    logic [3:0]         sel_idx;
    logic [BLOCK_W-1:0] src_block;
    logic [BLOCK_W-1:0] block_reg;
    logic [7:0]         sel_byte;

    logic [7:0]         shift_reg;
    logic [3:0]         dig_hund;
    logic [3:0]         dig_tens;
    logic [3:0]         dig_ones;
    logic [2:0]         bit_cnt;
    logic [19:0]        dabble_nxt;
    logic               conv_last;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 after the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Byte 0 is the most significant byte of the block (AES byte order).
    function automatic logic [7:0] pick_byte(input logic [BLOCK_W-1:0] blk,
                                             input logic [3:0]         idx);
        logic [BLOCK_W-1:0] tmp;
        tmp = blk << {idx, 3'b000};
        return tmp[BLOCK_W-1 -: 8];
    endfunction

    // Two-flop synchronizer for the asynchronous button; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_sync_p0 <= 1'b1;
            step_sync_p1 <= 1'b1;
        end else begin
            step_sync_p0 <= step_n;
            step_sync_p1 <= step_sync_p0;
        end
    end

    // The counter runs while the synchronized level differs from the current debounced state.
    assign db_active = (step_sync_p1 == db_pressed);
    assign press_evt = !db_pressed && db_active && (db_cnt == DB_LAST);

    // Debouncer: flip state after DB_CYCLES consecutive opposite samples; any bounce restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_pressed <= 1'b0;
            db_cnt     <= '0;
        end else if (db_active) begin
            if (db_cnt == DB_LAST) begin
                db_pressed <= !db_pressed;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Load beats a simultaneous press; the press is simply dropped.
    assign trigger    = load || press_evt;
    assign sel_idx    = load ? 4'd0 : byte_idx + 4'd1;
    assign src_block  = load ? block_in : block_reg;
    assign sel_byte   = pick_byte(src_block, sel_idx);
    assign dabble_nxt = {dabble_adj(dig_hund), dabble_adj(dig_tens),
                         dabble_adj(dig_ones), shift_reg} << 1;
    assign conv_last  = (state == CONV) && (bit_cnt == 3'd7);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: any trigger (re)starts a conversion, the eighth shift ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = CONV;
            CONV:    if (trigger) state_nxt = CONV;
                     else if (conv_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte selection and conversion datapath; outputs hold until a conversion completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_reg <= '0;
            byte_idx  <= 4'd0;
            byte_val  <= 8'd0;
            shift_reg <= 8'd0;
            dig_hund  <= 4'd0;
            dig_tens  <= 4'd0;
            dig_ones  <= 4'd0;
            bit_cnt   <= 3'd0;
            bcd_hund  <= 4'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
            bcd_valid <= 1'b0;
        end else if (trigger) begin
            block_reg <= src_block;
            byte_idx  <= sel_idx;
            byte_val  <= sel_byte;
            shift_reg <= sel_byte;
            dig_hund  <= 4'd0;
            dig_tens  <= 4'd0;
            dig_ones  <= 4'd0;
            bit_cnt   <= 3'd0;
            bcd_valid <= 1'b0;
        end else if (state == CONV) begin
            {dig_hund, dig_tens, dig_ones, shift_reg} <= dabble_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (conv_last) begin
                bcd_hund  <= dabble_nxt[19:16];
                bcd_tens  <= dabble_nxt[15:12];
                bcd_ones  <= dabble_nxt[11:8];
                bcd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cipher_result_pager.sv
// Bench for cipher_result_pager: directed scenarios with literal expectations plus a
// behavioural model (run-length debounce, decimal division) compared every cycle.
module tb_cipher_result_pager;

    localparam int DB = 4;

    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2 = 128'ha53c0f7e0000000000000000000000ff;
    localparam logic [127:0] B3 = 128'h07c86400000000000000000000000001;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] block_in;
    logic         step_n;
    logic [3:0]   byte_idx;
    logic [7:0]   byte_val;
    logic [3:0]   bcd_hund;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic         bcd_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [127:0] m_block;
    logic [3:0]   m_idx;
    logic [7:0]   m_val;
    logic [3:0]   m_h;
    logic [3:0]   m_t;
    logic [3:0]   m_o;
    logic         m_valid;
    int           m_left;
    logic [1:0]   m_sync;
    int           m_low;
    int           m_high;
    logic         m_pressed;
    logic         m_ev;
    logic         m_trig;

    cipher_result_pager #(.BLOCK_W(128), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .block_in  (block_in),
        .step_n    (step_n),
        .byte_idx  (byte_idx),
        .byte_val  (byte_val),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .bcd_valid (bcd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        return b[127-8*i -: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: debounce as consecutive-run lengths, conversion as an 8-edge countdown.
    always @(posedge clk) begin
        if (rst) begin
            m_block = '0; m_idx = 4'd0; m_val = 8'd0;
            m_h = 4'd0; m_t = 4'd0; m_o = 4'd0; m_valid = 1'b0; m_left = 0;
            m_sync = 2'b11; m_low = 0; m_high = 0; m_pressed = 1'b0;
        end else begin
            m_ev = 1'b0;
            if (m_sync[1]) begin m_high++; m_low = 0; end
            else begin m_low++; m_high = 0; end
            if (!m_pressed && m_low >= DB) begin m_ev = 1'b1; m_pressed = 1'b1; end
            else if (m_pressed && m_high >= DB) m_pressed = 1'b0;
            m_sync = {m_sync[0], step_n};
            m_trig = 1'b0;
            if (load) begin m_block = block_in; m_idx = 4'd0; m_trig = 1'b1; end
            else if (m_ev) begin m_idx = 4'(m_idx + 1); m_trig = 1'b1; end
            if (m_trig) begin
                m_val = byte_of(m_block, int'(m_idx));
                m_valid = 1'b0;
                m_left = 8;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_h = 4'(m_val / 100);
                    m_t = 4'((m_val / 10) % 10);
                    m_o = 4'(m_val % 10);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_idx",   32'(byte_idx),  32'(m_idx));
            check("mdl_val",   32'(byte_val),  32'(m_val));
            check("mdl_valid", 32'(bcd_valid), 32'(m_valid));
            check("mdl_hund",  32'(bcd_hund),  32'(m_h));
            check("mdl_tens",  32'(bcd_tens),  32'(m_t));
            check("mdl_ones",  32'(bcd_ones),  32'(m_o));
        end
    end

    task automatic press();
        step_n = 1'b0;
        repeat (6) @(negedge clk);
        step_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic glitch();
        step_n = 1'b0;
        repeat (3) @(negedge clk);
        step_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_disp(input string name, input logic [3:0] idx, input logic [7:0] val,
                              input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        check({name, "_idx"},   32'(byte_idx),  32'(idx));
        check({name, "_val"},   32'(byte_val),  32'(val));
        check({name, "_valid"}, 32'(bcd_valid), 32'd1);
        check({name, "_hund"},  32'(bcd_hund),  32'(h));
        check({name, "_tens"},  32'(bcd_tens),  32'(t));
        check({name, "_ones"},  32'(bcd_ones),  32'(o));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; step_n = 1'b1; block_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_idx",   32'(byte_idx),  32'd0);
        check("rst_val",   32'(byte_val),  32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_hund",  32'(bcd_hund),  32'd0);

        // T1: load, 8-edge latency
        load = 1'b1; block_in = B1;
        @(negedge clk);
        load = 1'b0;
        check("t1_idx",   32'(byte_idx),  32'd0);
        check("t1_val",   32'(byte_val),  32'h00);
        check("t1_valid", 32'(bcd_valid), 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t1_valid_low", 32'(bcd_valid), 32'd0);
        end
        @(negedge clk);
        check_disp("t1", 4'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        check("t1_model_valid", 32'(m_valid), 32'd1);

        // T2: one clean press, then a short glitch
        press();
        check_disp("t2", 4'd1, 8'h11, 4'd0, 4'd1, 4'd7);
        check("t2_model_ones", 32'(m_o), 32'd7);
        glitch();
        check("t2_glitch_idx", 32'(byte_idx), 32'd1);

        // T3: walk to the last byte and wrap
        for (int k = 0; k < 14; k++) press();
        check_disp("t3", 4'd15, 8'hff, 4'd2, 4'd5, 4'd5);
        check("t3_model_hund", 32'(m_h), 32'd2);
        press();
        check_disp("t3_wrap", 4'd0, 8'h00, 4'd0, 4'd0, 4'd0);

        // T4: byte 9, then load coinciding with a press event
        for (int k = 0; k < 9; k++) press();
        check_disp("t4", 4'd9, 8'h99, 4'd1, 4'd5, 4'd3);
        step_n = 1'b0;
        repeat (5) @(negedge clk);
        load = 1'b1; block_in = B2;
        @(negedge clk);
        load = 1'b0; step_n = 1'b1;
        check("t4_coll_idx", 32'(byte_idx), 32'd0);
        check("t4_coll_val", 32'(byte_val), 32'ha5);
        repeat (8) @(negedge clk);
        check_disp("t4_coll", 4'd0, 8'ha5, 4'd1, 4'd6, 4'd5);

        // T5: press three cycles into a conversion restarts it
        step_n = 1'b0;
        repeat (2) @(negedge clk);
        load = 1'b1; block_in = B3;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        step_n = 1'b1;
        check("t5_idx",   32'(byte_idx),  32'd1);
        check("t5_val",   32'(byte_val),  32'hc8);
        check("t5_valid", 32'(bcd_valid), 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t5_valid_low", 32'(bcd_valid), 32'd0);
        end
        @(negedge clk);
        check_disp("t5", 4'd1, 8'hc8, 4'd2, 4'd0, 4'd0);

        // T5b: reset in the middle of a conversion
        step_n = 1'b0;
        repeat (6) @(negedge clk);
        step_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5r_idx",   32'(byte_idx),  32'd0);
        check("t5r_val",   32'(byte_val),  32'd0);
        check("t5r_valid", 32'(bcd_valid), 32'd0);
        check("t5r_hund",  32'(bcd_hund),  32'd0);
        repeat (10) @(negedge clk);
        check("t5r_valid_after", 32'(bcd_valid), 32'd0);

        // T6: random blocks, button activity, loads and occasional reset
        for (int c = 0; c < 800; c++) begin
            load = ($urandom_range(0, 24) == 0);
            if (load) block_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) step_n = ~step_n;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0; step_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
